dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters: the core load/store path and a loader/debug port used for program and data upload.
- The core is the default owner. The loader runs word-aligned, auto-incrementing bursts of up to MAX_BURST beats.
- A starvation counter guarantees the loader progress. A guard cycle after each burst guarantees the core progress.
- The core is stalled (PC held) whenever its request is not granted.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the core owns the port by default, the loader gets
// word bursts, a starvation counter and a post-burst guard cycle keep both moving.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [2:0]        core_funct3,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [4:0]        ldr_len,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GUARD} state_t;

  state_t            state, state_nx;
  logic              burst_we, burst_we_nx;
  logic [ADDR_W-1:0] burst_addr, burst_addr_nx;
  logic [BW-1:0]     beats, beats_nx;
  logic [BW-1:0]     beat_cnt, beat_cnt_nx;
  logic [SW-1:0]     starve_cnt, starve_nx;

  logic [BW-1:0]     req_beats;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_we;
  logic              core_gnt_i, ldr_gnt_i, ldr_done_i;

  // Zero-length requests still move one word; longer ones are clamped.
  always_comb begin
    if (ldr_len == '0)
      req_beats = BW'(1);
    else if (int'(ldr_len) > MAX_BURST)
      req_beats = BW'(MAX_BURST);
    else
      req_beats = BW'(ldr_len);
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    burst_we_nx   = burst_we;
    burst_addr_nx = burst_addr;
    beats_nx      = beats;
    beat_cnt_nx   = beat_cnt;
    core_gnt_i    = 1'b0;
    ldr_gnt_i     = 1'b0;
    ldr_done_i    = 1'b0;
    beat_addr     = '0;
    beat_we       = 1'b0;

    case (state)
      S_IDLE: begin
        if (core_req && (starve_cnt < SW'(STARVE_LIMIT))) begin
          core_gnt_i = 1'b1;
        end else if (ldr_req) begin
          ldr_gnt_i     = 1'b1;
          beat_addr     = ldr_addr & ~ADDR_W'(3);
          beat_we       = ldr_we;
          burst_we_nx   = ldr_we;
          burst_addr_nx = ldr_addr & ~ADDR_W'(3);
          beats_nx      = req_beats;
          if (req_beats == BW'(1)) begin
            ldr_done_i = 1'b1;
            state_nx   = S_GUARD;
          end else begin
            beat_cnt_nx = BW'(1);
            state_nx    = S_BURST;
          end
        end
      end

      S_BURST: begin
        if (ldr_req) begin
          ldr_gnt_i = 1'b1;
          beat_we   = burst_we;
          beat_addr = burst_addr + (ADDR_W'(beat_cnt) << 2);
          if (beat_cnt == beats - BW'(1)) begin
            ldr_done_i = 1'b1;
            state_nx   = S_GUARD;
          end else begin
            beat_cnt_nx = beat_cnt + BW'(1);
          end
        end else begin
          // Loader dropped its request mid-burst: close the burst without a beat.
          ldr_done_i = 1'b1;
          state_nx   = S_GUARD;
        end
      end

      S_GUARD: begin
        core_gnt_i = core_req;
        state_nx   = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    starve_nx = '0;
    if (ldr_req && !ldr_gnt_i)
      starve_nx = (starve_cnt < SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state      <= S_IDLE;
      burst_we   <= 1'b0;
      burst_addr <= '0;
      beats      <= '0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      burst_we   <= burst_we_nx;
      burst_addr <= burst_addr_nx;
      beats      <= beats_nx;
      beat_cnt   <= beat_cnt_nx;
      starve_cnt <= starve_nx;
    end
  end

  // Reset blanks every grant in the same cycle so memory sees no access.
  assign core_gnt   = core_gnt_i & ~rst_;
  assign ldr_gnt    = ldr_gnt_i & ~rst_;
  assign ldr_done   = ldr_done_i & ~rst_;
  assign core_stall = core_req & ~core_gnt;
  assign busy       = (state != S_IDLE) & ~rst_;

  assign core_rdata = mem_rdata;
  assign ldr_rdata  = mem_rdata;

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = 3'b000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (core_gnt) begin
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
      mem_read   = ~core_we;
      mem_write  = core_we;
    end else if (ldr_gnt) begin
      mem_addr   = beat_addr;
      mem_wdata  = ldr_wdata;
      mem_funct3 = 3'b010;
      mem_read   = ~beat_we;
      mem_write  = beat_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: drives a small word memory model and checks
// grants, addresses, burst framing, starvation priority and reset behaviour.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_funct3;
  logic        core_gnt, core_stall;
  logic [31:0] core_rdata;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic [4:0]  ldr_len;
  logic        ldr_gnt, ldr_done;
  logic [31:0] ldr_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic        busy;

  int passed = 0;
  int total  = 0;

  int          beats_seen;
  logic        done_seen;
  logic [31:0] last_addr;
  logic [31:0] wrap_addr [3];

  logic [31:0] mem_arr [0:1023];

  always #5 clk = ~clk;

  assign mem_rdata = mem_arr[mem_addr[11:2]];
  always @(posedge clk) if (mem_write) mem_arr[mem_addr[11:2]] <= mem_wdata;

  dmem_arbiter dut (
    .clk(clk), .rst_(rst_),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_funct3(core_funct3), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_len(ldr_len),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata),
    .ldr_done(ldr_done),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst_ = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_funct3 = '0; core_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_len = '0; ldr_wdata = '0;

    // Reset: no grants, stall mirrors core_req.
    @(negedge clk);
    check("rst core_gnt", core_gnt, 0);
    check("rst core_stall", core_stall, 1);
    check("rst busy", busy, 0);
    check("rst mem_read", mem_read, 0);
    next_cycle();
    rst_ = 1'b0;

    // Core store then load of 0x100.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100;
    core_wdata = 32'hDEAD_BEEF; core_funct3 = 3'b010;
    @(negedge clk);
    check("core st gnt", core_gnt, 1);
    check("core st stall", core_stall, 0);
    check("core st mem_write", mem_write, 1);
    check("core st mem_addr", mem_addr, 32'h100);
    check("core st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    core_we = 1'b0; core_funct3 = 3'b100;
    @(negedge clk);
    check("core ld gnt", core_gnt, 1);
    check("core ld mem_read", mem_read, 1);
    check("core ld funct3", mem_funct3, 3'b100);
    check("core ld rdata", core_rdata, 32'hDEAD_BEEF);
    next_cycle();
    core_req = 1'b0;

    // Loader write burst of 4 from 0x203; mid-burst input changes are ignored.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h203; ldr_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      ldr_wdata = 32'hA0 + i;
      if (i > 0) begin
        ldr_addr = 32'h0F00; ldr_len = 5'd1; ldr_we = 1'b0;
      end
      @(negedge clk);
      check("wr burst gnt", ldr_gnt, 1);
      check("wr burst addr", mem_addr, 32'h200 + 4 * i);
      check("wr burst mem_write", mem_write, 1);
      check("wr burst funct3", mem_funct3, 3'b010);
      check("wr burst done", ldr_done, (i == 3) ? 1 : 0);
      check("wr burst busy", busy, (i == 0) ? 0 : 1);
      next_cycle();
    end
    ldr_req = 1'b0;
    @(negedge clk);
    check("wr guard busy", busy, 1);
    check("wr guard ldr_gnt", ldr_gnt, 0);
    next_cycle();
    @(negedge clk);
    check("wr idle busy", busy, 0);
    next_cycle();

    // Contention: core holds 8 cycles, then the starved loader takes a 2-beat burst.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h208; core_funct3 = 3'b010;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h300; ldr_len = 5'd2; ldr_wdata = 32'h55;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cont core gnt", core_gnt, 1);
      check("cont ldr gnt", ldr_gnt, 0);
      if (i == 0) check("cont core rdata", core_rdata, 32'hA2);
      next_cycle();
    end
    core_funct3 = 3'b000;
    @(negedge clk);
    check("cont beat0 gnt", ldr_gnt, 1);
    check("cont beat0 stall", core_stall, 1);
    check("cont beat0 addr", mem_addr, 32'h300);
    check("cont beat0 funct3", mem_funct3, 3'b010);
    next_cycle();
    @(negedge clk);
    check("cont beat1 gnt", ldr_gnt, 1);
    check("cont beat1 done", ldr_done, 1);
    check("cont beat1 stall", core_stall, 1);
    check("cont beat1 addr", mem_addr, 32'h304);
    next_cycle();
    @(negedge clk);
    check("cont guard core", core_gnt, 1);
    check("cont guard ldr", ldr_gnt, 0);
    check("cont guard busy", busy, 1);
    next_cycle();
    @(negedge clk);
    check("cont idle core", core_gnt, 1);
    check("cont idle ldr", ldr_gnt, 0);
    next_cycle();
    core_req = 1'b0; ldr_req = 1'b0;
    next_cycle();

    // Clamp: ldr_len=20 gives exactly MAX_BURST beats.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h400; ldr_len = 5'd20;
    beats_seen = 0; done_seen = 1'b0; last_addr = '0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge clk);
      if (ldr_gnt) beats_seen++;
      if (ldr_done) begin
        done_seen = 1'b1;
        last_addr = mem_addr;
      end
      next_cycle();
    end
    check("clamp beats", beats_seen, 16);
    check("clamp done", done_seen, 1);
    check("clamp last addr", last_addr, 32'h43C);
    ldr_req = 1'b0;
    @(negedge clk);
    check("clamp guard busy", busy, 1);
    next_cycle();

    // Zero length: single read beat from 0x201 (aligned to 0x200) with done.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h201; ldr_len = 5'd0;
    @(negedge clk);
    check("len0 gnt", ldr_gnt, 1);
    check("len0 done", ldr_done, 1);
    check("len0 addr", mem_addr, 32'h200);
    check("len0 mem_read", mem_read, 1);
    check("len0 rdata", ldr_rdata, 32'hA0);
    next_cycle();
    ldr_req = 1'b0;
    @(negedge clk);
    check("len0 guard busy", busy, 1);
    check("len0 guard gnt", ldr_gnt, 0);
    next_cycle();
    @(negedge clk);
    check("len0 idle busy", busy, 0);
    next_cycle();

    // Abort and wrap: 3 beats across the top of the address space, then drop.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'hFFFF_FFF8; ldr_len = 5'd4; ldr_wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wrap gnt", ldr_gnt, 1);
      check("wrap addr", mem_addr, wrap_addr[i]);
      check("wrap done", ldr_done, 0);
      next_cycle();
    end
    ldr_req = 1'b0;
    @(negedge clk);
    check("abort done", ldr_done, 1);
    check("abort gnt", ldr_gnt, 0);
    check("abort mem_write", mem_write, 0);
    check("abort busy", busy, 1);
    next_cycle();
    @(negedge clk);
    check("abort guard busy", busy, 1);
    check("abort guard done", ldr_done, 0);
    next_cycle();
    @(negedge clk);
    check("abort idle busy", busy, 0);
    next_cycle();

    // Reset at beat 2 of an 8-beat burst; a fresh burst follows.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h600; ldr_len = 5'd8;
    @(negedge clk);
    check("rstb beat0 addr", mem_addr, 32'h600);
    next_cycle();
    @(negedge clk);
    check("rstb beat1 addr", mem_addr, 32'h604);
    next_cycle();
    rst_ = 1'b1; core_req = 1'b1;
    @(negedge clk);
    check("rstb mem_write", mem_write, 0);
    check("rstb ldr_gnt", ldr_gnt, 0);
    check("rstb done", ldr_done, 0);
    check("rstb busy", busy, 0);
    check("rstb core_gnt", core_gnt, 0);
    check("rstb core_stall", core_stall, 1);
    check("rstb mem_addr", mem_addr, 0);
    next_cycle();
    rst_ = 1'b0; core_req = 1'b0; ldr_addr = 32'h700; ldr_len = 5'd2;
    @(negedge clk);
    check("fresh beat0 gnt", ldr_gnt, 1);
    check("fresh beat0 busy", busy, 0);
    check("fresh beat0 addr", mem_addr, 32'h700);
    next_cycle();
    @(negedge clk);
    check("fresh beat1 addr", mem_addr, 32'h704);
    check("fresh beat1 done", ldr_done, 1);
    next_cycle();
    ldr_req = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
